// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext -- single-clock FIFO with occupancy flags and sticky errors.
//
// Ports:
//   clk          sole clock, all state updates on its rising edge
//   reset        asynchronous active-high reset
//   wren/datain  write request and data
//   rden         read request
//   flush        synchronous clear of contents (overrides wren/rden)
//   err_clr      clears overflow/underflow (a same-cycle set wins)
//   dataout      read data (registered, or first-word-fall-through when SHOWAHEAD=1)
//   full/empty/almost_full/almost_empty
//                decoded from the usedw register
//   usedw        occupancy, 0..DEPTH
//   overflow     sticky: a write was rejected
//   underflow    sticky: a read was attempted on empty
module sync_fifo_ext #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 16,
   parameter int PTR        = 4,
   parameter int AFULL_THR  = 14,
   parameter int AEMPTY_THR = 2,
   parameter int SHOWAHEAD  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wren,
   input  logic [WIDTH-1:0] datain,
   input  logic             rden,
   input  logic             flush,
   input  logic             err_clr,
   output logic [WIDTH-1:0] dataout,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [PTR:0]     usedw,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [PTR:0] DEPTH_U  = (PTR+1)'(DEPTH);
   localparam logic [PTR:0] AFULL_U  = (PTR+1)'(AFULL_THR);
   localparam logic [PTR:0] AEMPTY_U = (PTR+1)'(AEMPTY_THR);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR-1:0]   wr_ptr, rd_ptr;
   logic             rd_acc, wr_acc;
   logic             ovf_set, udf_set;

   assign full         = (usedw == DEPTH_U);
   assign empty        = (usedw == '0);
   assign almost_full  = (usedw >= AFULL_U);
   assign almost_empty = (usedw <= AEMPTY_U);

   // A write into a full FIFO is still taken when a read frees the slot
   // on the same edge; a read on empty never bypasses datain.
   assign rd_acc  = rden & ~empty & ~flush;
   assign wr_acc  = wren & ~flush & (~full | rd_acc);
   assign ovf_set = wren & ~flush & ~wr_acc;
   assign udf_set = rden & ~flush & empty;

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= datain;
   end

   // Pointers wrap naturally since DEPTH == 2**PTR.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         usedw  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         usedw  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   usedw <= usedw + 1'b1;
            2'b01:   usedw <= usedw - 1'b1;
            default: usedw <= usedw;
         endcase
      end
   end

   // Sticky errors: set beats clear, flush leaves them alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= ovf_set | (overflow  & ~err_clr);
         underflow <= udf_set | (underflow & ~err_clr);
      end
   end

   generate
      if (SHOWAHEAD != 0) begin : g_fwft
         // Head word shown directly; forced to 0 so a flushed/empty FIFO
         // never exposes stale memory.
         assign dataout = empty ? '0 : mem[rd_ptr];
      end else begin : g_reg
         logic [WIDTH-1:0] dout_q;
         always_ff @(posedge clk or posedge reset) begin
            if (reset)       dout_q <= '0;
            else if (rd_acc) dout_q <= mem[rd_ptr];
         end
         assign dataout = dout_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: two instances (registered read and show-ahead)
// share one stimulus stream and are compared with a queue-based model.
module tb_sync_fifo_ext;

   localparam int W = 8;
   localparam int D = 16;
   localparam int P = 4;
   localparam int AF = 14;
   localparam int AE = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         wren = 1'b0, rden = 1'b0, flush = 1'b0, err_clr = 1'b0;
   logic [W-1:0] datain = '0;

   logic [W-1:0] dout0, dout1;
   logic         full0, empty0, af0, ae0, ovf0, udf0;
   logic         full1, empty1, af1, ae1, ovf1, udf1;
   logic [P:0]   used0, used1;

   sync_fifo_ext #(.WIDTH(W), .DEPTH(D), .PTR(P), .AFULL_THR(AF), .AEMPTY_THR(AE), .SHOWAHEAD(0)) u_reg (
      .clk(clk), .reset(reset), .wren(wren), .datain(datain), .rden(rden), .flush(flush),
      .err_clr(err_clr), .dataout(dout0), .full(full0), .empty(empty0), .almost_full(af0),
      .almost_empty(ae0), .usedw(used0), .overflow(ovf0), .underflow(udf0));

   sync_fifo_ext #(.WIDTH(W), .DEPTH(D), .PTR(P), .AFULL_THR(AF), .AEMPTY_THR(AE), .SHOWAHEAD(1)) u_fwft (
      .clk(clk), .reset(reset), .wren(wren), .datain(datain), .rden(rden), .flush(flush),
      .err_clr(err_clr), .dataout(dout1), .full(full1), .empty(empty1), .almost_full(af1),
      .almost_empty(ae1), .usedw(used1), .overflow(ovf1), .underflow(udf1));

   always #5 clk = ~clk;

   // reference model
   logic [W-1:0] q[$];
   logic [W-1:0] m_dout0;
   logic         m_ovf, m_udf;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      check({tag, ".usedw0"}, 32'(used0), 32'(n));
      check({tag, ".usedw1"}, 32'(used1), 32'(n));
      check({tag, ".full"},   32'(full0),  32'(n == D));
      check({tag, ".empty"},  32'(empty0), 32'(n == 0));
      check({tag, ".afull"},  32'(af0),    32'(n >= AF));
      check({tag, ".aempty"}, 32'(ae0),    32'(n <= AE));
      check({tag, ".full1"},  32'({full1, empty1, af1, ae1}),
            32'({n == D, n == 0, n >= AF, n <= AE}));
      check({tag, ".ovf"},    32'({ovf1, ovf0}), 32'({m_ovf, m_ovf}));
      check({tag, ".udf"},    32'({udf1, udf0}), 32'({m_udf, m_udf}));
      check({tag, ".dout0"},  32'(dout0), 32'(m_dout0));
      check({tag, ".dout1"},  32'(dout1), 32'((n > 0) ? q[0] : 8'h00));
   endtask

   // One clock with the given request; model follows the FIFO rules directly.
   task automatic cycle(input logic w, input logic r, input logic f, input logic ec,
                        input logic [W-1:0] d, input string tag);
      logic was_full, was_empty, racc, wacc;
      wren = w; rden = r; flush = f; err_clr = ec; datain = d;
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      racc = r && !was_empty && !f;
      wacc = w && !f && (!was_full || racc);
      @(posedge clk);
      if (f) q.delete();
      else begin
         if (racc) m_dout0 = q.pop_front();
         if (wacc) q.push_back(d);
      end
      m_ovf = (w && !f && !wacc) ? 1'b1 : (ec ? 1'b0 : m_ovf);
      m_udf = (r && !f && was_empty) ? 1'b1 : (ec ? 1'b0 : m_udf);
      #1;
      wren = 0; rden = 0; flush = 0; err_clr = 0;
      check_all(tag);
   endtask

   task automatic model_reset();
      q.delete();
      m_dout0 = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   initial begin
      model_reset();
      // reset with no clock edge yet
      #2 check_all("rst0");
      // requests during reset are ignored and set no error
      wren = 1; rden = 1; datain = 8'h77;
      @(posedge clk); #1 check_all("rst_req");
      wren = 0; rden = 0; reset = 0;

      // fill 0x01..0x10
      for (int i = 1; i <= 16; i++) cycle(1, 0, 0, 0, 8'(i), $sformatf("fill%0d", i));
      check("fill.full_lit", 32'({full0, af0, used0}), 32'({1'b1, 1'b1, 5'd16}));
      cycle(1, 0, 0, 0, 8'h11, "ovf17");
      check("ovf17.lit", 32'({ovf0, used0}), 32'({1'b1, 5'd16}));
      cycle(0, 0, 0, 1, 8'h00, "errclr");
      // full: simultaneous write/read keeps occupancy, no overflow
      cycle(1, 1, 0, 0, 8'hAA, "full_wr_rd");
      check("full_wr_rd.lit", 32'({ovf0, used0, dout0}), 32'({1'b0, 5'd16, 8'h01}));
      for (int i = 2; i <= 17; i++) cycle(0, 1, 0, 0, 8'h00, $sformatf("rd%0d", i));
      check("rd16.aa", 32'(dout0), 32'h0000_00AA);
      check("rd.empty_lit", 32'(empty0), 32'd1);
      cycle(0, 1, 0, 0, 8'h00, "udf");
      check("udf.lit", 32'(udf0), 32'd1);
      cycle(0, 0, 0, 1, 8'h00, "errclr2");

      // show-ahead: word visible the cycle after the write
      cycle(1, 0, 0, 0, 8'h5A, "fwft5a");
      check("fwft5a.lit", 32'(dout1), 32'h5A);
      cycle(0, 1, 0, 0, 8'h00, "fwft_rd");
      // write+read at empty: write taken, read rejected
      cycle(1, 1, 0, 0, 8'h3C, "empty_wr_rd");
      cycle(0, 0, 0, 1, 8'h00, "errclr3");
      cycle(0, 1, 0, 0, 8'h00, "drain");

      // flush keeps sticky flags; set beats clear
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 8'(8'h20 + i), "w5");
      cycle(0, 1, 1, 0, 8'h00, "flush");
      for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0, 8'(8'h40 + i), "refill");
      cycle(1, 0, 0, 0, 8'hEE, "ovf_again");
      cycle(1, 0, 1, 0, 8'hEE, "flush_keep");
      for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0, 8'(8'h60 + i), "refill2");
      cycle(1, 0, 0, 1, 8'hEF, "set_wins");
      check("set_wins.lit", 32'(ovf0), 32'd1);

      // randomized traffic, pointers wrap many times
      for (int i = 0; i < 400; i++) begin
         logic w, r, f, ec;
         w  = ($urandom_range(0, 99) < 55);
         r  = ($urandom_range(0, 99) < 50);
         f  = ($urandom_range(0, 99) < 3);
         ec = ($urandom_range(0, 99) < 8);
         cycle(w, r, f, ec, 8'($urandom), "rand");
      end

      // wrap then asynchronous reset between edges
      for (int i = 0; i < 24; i++) cycle(1, (i % 3) != 0, 0, 0, 8'(8'h80 + i), "wrap");
      cycle(1, 0, 0, 0, 8'h99, "prerst");
      #2 reset = 1;
      model_reset();
      #1 check_all("async_rst");
      wren = 1; rden = 1; datain = 8'h55;
      @(posedge clk); #1 check_all("rst_hold");
      wren = 0; rden = 0; reset = 0;
      cycle(1, 0, 0, 0, 8'hC3, "post_w1");
      cycle(1, 0, 0, 0, 8'hC4, "post_w2");
      cycle(0, 1, 0, 0, 8'h00, "post_rd");
      check("post_rd.first", 32'(dout0), 32'hC3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
